// File: rtl/skf_exhaustive_checker.sv
`default_nettype none
// ============================================================================
// Module      : skf_exhaustive_checker
// Description : Exhaustive sweep sequencer that compares a synthesized Skolem
//               function against a golden function over every NUM_IN-bit
//               input assignment. It counts mismatching vectors and records
//               the first failing vector.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk              in   1         clock, rising edge
//   rst_n            in   1         asynchronous active-low reset
//   start            in   1         begin a sweep (sampled only in IDLE)
//   abort            in   1         terminate the sweep (wins over start/done)
//   eval_vec         out  NUM_IN    registered assignment to DUT and golden
//   dut_out          in   1         DUT Skolem output (comb. from eval_vec)
//   gold_out         in   1         golden output (comb. from eval_vec)
//   busy             out  1         high in every state except IDLE
//   done             out  1         one-cycle pulse on normal completion
//   pass             out  1         completed sweep had zero mismatches
//   mismatch_cnt     out  NUM_IN+1  number of mismatching vectors
//   first_fail_vec   out  NUM_IN    eval_vec at the first mismatch
//   first_fail_valid out  1         first_fail_vec is meaningful
// ============================================================================
module skf_exhaustive_checker #(
  parameter int NUM_IN       = 8,
  parameter int SETTLE       = 0,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [NUM_IN-1:0] eval_vec,
  input  logic              dut_out,
  input  logic              gold_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [NUM_IN:0]   mismatch_cnt,
  output logic [NUM_IN-1:0] first_fail_vec,
  output logic              first_fail_valid
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [3:0]        SETTLE_CNT = 4'(SETTLE);
  localparam bit                STOP_EARLY = (STOP_ON_FAIL != 0);
  localparam logic [NUM_IN-1:0] VEC_ONE    = NUM_IN'(1);
  localparam logic [NUM_IN:0]   CNT_ONE    = (NUM_IN + 1)'(1);

  state_t     state;
  logic [3:0] wait_cnt;
  logic       mism;

  assign mism = (dut_out != gold_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      wait_cnt         <= 4'd0;
      eval_vec         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      mismatch_cnt     <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      // done is asserted only for the single cycle spent in FINISH
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !abort) begin
            eval_vec         <= '0;
            mismatch_cnt     <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
            wait_cnt         <= SETTLE_CNT;
            busy             <= 1'b1;
            state            <= (SETTLE_CNT == 4'd0) ? CHECK : WAIT;
          end
        end

        WAIT: begin
          if (abort) begin
            busy  <= 1'b0;
            pass  <= 1'b0;
            state <= IDLE;
          end else begin
            // SETTLE cycles in WAIT plus one in CHECK per vector
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt <= 4'd1) begin
              state <= CHECK;
            end
          end
        end

        CHECK: begin
          if (abort) begin
            // the comparison of this cycle is discarded
            busy  <= 1'b0;
            pass  <= 1'b0;
            state <= IDLE;
          end else begin
            if (mism) begin
              mismatch_cnt <= mismatch_cnt + CNT_ONE;
              if (!first_fail_valid) begin
                first_fail_vec   <= eval_vec;
                first_fail_valid <= 1'b1;
              end
            end
            if ((mism && STOP_EARLY) || (&eval_vec)) begin
              // eval_vec is held; no wrap past all-ones
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              eval_vec <= eval_vec + VEC_ONE;
              wait_cnt <= SETTLE_CNT;
              state    <= (SETTLE_CNT == 4'd0) ? CHECK : WAIT;
            end
          end
        end

        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
          // mismatch_cnt already includes any mismatch from the last CHECK
          pass  <= abort ? 1'b0 : (mismatch_cnt == '0);
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_skf_exhaustive_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_skf_exhaustive_checker
// Description : Directed self-checking bench for skf_exhaustive_checker.
//               Three instances cover the full-sweep, early-stop and settle
//               configurations; the DUT function is selected per instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skf_exhaustive_checker;

  logic       clk;
  logic       rst_n;
  logic [2:0] start_v;
  logic [2:0] abort_v;
  logic [2:0] dut_v;
  logic [2:0] gold_v;
  logic [2:0] busy_v;
  logic [2:0] done_v;
  logic [2:0] pass_v;
  logic [2:0] ffvalid_v;
  logic [7:0] vec_v   [3];
  logic [8:0] cnt_v   [3];
  logic [7:0] ffvec_v [3];
  int         mode_v  [3];

  int errors;
  int checks;

  // 0: DUT matches golden, 1: DUT inverted, 2: DUT wrong only at 0xA5
  function automatic logic dut_fn(input logic [7:0] v, input int m);
    logic g;
    g = ~^v;
    if (m == 1) return ~g;
    if (m == 2 && v == 8'hA5) return ~g;
    return g;
  endfunction

  assign gold_v[0] = ~^vec_v[0];
  assign gold_v[1] = ~^vec_v[1];
  assign gold_v[2] = ~^vec_v[2];
  assign dut_v[0]  = dut_fn(vec_v[0], mode_v[0]);
  assign dut_v[1]  = dut_fn(vec_v[1], mode_v[1]);
  assign dut_v[2]  = dut_fn(vec_v[2], mode_v[2]);

  skf_exhaustive_checker #(.NUM_IN(8), .SETTLE(0), .STOP_ON_FAIL(0)) u_base (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .eval_vec(vec_v[0]), .dut_out(dut_v[0]), .gold_out(gold_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .mismatch_cnt(cnt_v[0]), .first_fail_vec(ffvec_v[0]),
    .first_fail_valid(ffvalid_v[0])
  );

  skf_exhaustive_checker #(.NUM_IN(8), .SETTLE(0), .STOP_ON_FAIL(1)) u_stop (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .eval_vec(vec_v[1]), .dut_out(dut_v[1]), .gold_out(gold_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .mismatch_cnt(cnt_v[1]), .first_fail_vec(ffvec_v[1]),
    .first_fail_valid(ffvalid_v[1])
  );

  skf_exhaustive_checker #(.NUM_IN(8), .SETTLE(2), .STOP_ON_FAIL(0)) u_settle (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]),
    .eval_vec(vec_v[2]), .dut_out(dut_v[2]), .gold_out(gold_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .mismatch_cnt(cnt_v[2]), .first_fail_vec(ffvec_v[2]),
    .first_fail_valid(ffvalid_v[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses start on instance k and follows the sweep cycle by cycle.
  // Cycle 1 is the first cycle after the start edge. Returns the cycle in
  // which done was seen (-1 on timeout), the number of busy cycles and the
  // number of cycles where eval_vec differed from the expected step.
  // Exits one cycle after done, still at posedge+1.
  task automatic sweep(input int k, input int settle, output int done_cyc,
                       output int busy_cyc, output int step_err);
    done_cyc = -1;
    busy_cyc = 0;
    step_err = 0;
    start_v[k] = 1'b1;
    @(posedge clk); #1;
    start_v[k] = 1'b0;
    for (int c = 1; c <= 2000; c++) begin
      if (busy_v[k]) busy_cyc++;
      if (done_v[k]) begin
        done_cyc = c;
        break;
      end
      if (vec_v[k] !== 8'((c - 1) / (settle + 1))) step_err++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({busy_v[k], done_v[k], pass_v[k], ffvalid_v[k]} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_flags[%0d]: got %b want 0000", k,
                 {busy_v[k], done_v[k], pass_v[k], ffvalid_v[k]});
      end
      checks++;
      if (vec_v[k] !== 8'h00 || cnt_v[k] !== 9'h000 || ffvec_v[k] !== 8'h00) begin
        errors++;
        $display("FAIL reset_data[%0d]: vec=%h cnt=%h ffvec=%h want 00 000 00",
                 k, vec_v[k], cnt_v[k], ffvec_v[k]);
      end
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_match();
    int dc, bc, se;
    mode_v[0] = 0;
    sweep(0, 0, dc, bc, se);
    checks++;
    if (dc !== 257) begin errors++; $display("FAIL match_done_cycle: got %0d want 257", dc); end
    checks++;
    if (bc !== 257) begin errors++; $display("FAIL match_busy_cycles: got %0d want 257", bc); end
    checks++;
    if (se !== 0) begin errors++; $display("FAIL match_vec_steps: got %0d bad want 0", se); end
    checks++;
    if (pass_v[0] !== 1'b1) begin errors++; $display("FAIL match_pass: got %b want 1", pass_v[0]); end
    checks++;
    if (cnt_v[0] !== 9'd0) begin errors++; $display("FAIL match_cnt: got %0d want 0", cnt_v[0]); end
    checks++;
    if (ffvalid_v[0] !== 1'b0) begin errors++; $display("FAIL match_ffvalid: got %b want 0", ffvalid_v[0]); end
    checks++;
    if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL match_after: done=%b busy=%b want 0 0", done_v[0], busy_v[0]);
    end
    checks++;
    if (vec_v[0] !== 8'hFF) begin errors++; $display("FAIL match_vec_hold: got %h want ff", vec_v[0]); end
  endtask

  task automatic test_inverted();
    int dc, bc, se;
    mode_v[0] = 1;
    sweep(0, 0, dc, bc, se);
    checks++;
    if (dc !== 257) begin errors++; $display("FAIL inv_done_cycle: got %0d want 257", dc); end
    checks++;
    if (cnt_v[0] !== 9'h100) begin errors++; $display("FAIL inv_cnt: got %h want 100", cnt_v[0]); end
    checks++;
    if (ffvec_v[0] !== 8'h00 || ffvalid_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL inv_first: vec=%h valid=%b want 00 1", ffvec_v[0], ffvalid_v[0]);
    end
    checks++;
    if (pass_v[0] !== 1'b0) begin errors++; $display("FAIL inv_pass: got %b want 0", pass_v[0]); end
  endtask

  task automatic test_single_fault();
    int dc, bc, se;
    mode_v[0] = 2;
    sweep(0, 0, dc, bc, se);
    checks++;
    if (dc !== 257) begin errors++; $display("FAIL fault_done_cycle: got %0d want 257", dc); end
    checks++;
    if (cnt_v[0] !== 9'd1) begin errors++; $display("FAIL fault_cnt: got %0d want 1", cnt_v[0]); end
    checks++;
    if (ffvec_v[0] !== 8'hA5 || ffvalid_v[0] !== 1'b1) begin
      errors++;
      $display("FAIL fault_first: vec=%h valid=%b want a5 1", ffvec_v[0], ffvalid_v[0]);
    end
    checks++;
    if (pass_v[0] !== 1'b0) begin errors++; $display("FAIL fault_pass: got %b want 0", pass_v[0]); end
  endtask

  task automatic test_early_stop();
    int dc, bc, se;
    mode_v[1] = 2;
    sweep(1, 0, dc, bc, se);
    checks++;
    if (dc !== 167) begin errors++; $display("FAIL stop_done_cycle: got %0d want 167", dc); end
    checks++;
    if (se !== 0) begin errors++; $display("FAIL stop_vec_steps: got %0d bad want 0", se); end
    checks++;
    if (vec_v[1] !== 8'hA5) begin errors++; $display("FAIL stop_vec_hold: got %h want a5", vec_v[1]); end
    checks++;
    if (cnt_v[1] !== 9'd1 || ffvec_v[1] !== 8'hA5) begin
      errors++;
      $display("FAIL stop_result: cnt=%0d ffvec=%h want 1 a5", cnt_v[1], ffvec_v[1]);
    end
    checks++;
    if (pass_v[1] !== 1'b0) begin errors++; $display("FAIL stop_pass: got %b want 0", pass_v[1]); end
  endtask

  task automatic test_settle();
    int dc, bc, se;
    mode_v[2] = 0;
    sweep(2, 2, dc, bc, se);
    checks++;
    if (dc !== 769) begin errors++; $display("FAIL settle_done_cycle: got %0d want 769", dc); end
    checks++;
    if (se !== 0) begin errors++; $display("FAIL settle_vec_hold3: got %0d bad want 0", se); end
    checks++;
    if (bc !== 769) begin errors++; $display("FAIL settle_busy_cycles: got %0d want 769", bc); end
    checks++;
    if (pass_v[2] !== 1'b1) begin errors++; $display("FAIL settle_pass: got %b want 1", pass_v[2]); end
  endtask

  task automatic test_abort_restart_reset();
    int dc, bc, se, found, dones;
    mode_v[0] = 0;
    // start together with abort in IDLE must leave everything unchanged
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    checks++;
    if (busy_v[0] !== 1'b0 || ffvec_v[0] !== 8'hA5 || cnt_v[0] !== 9'd1) begin
      errors++;
      $display("FAIL start_abort_idle: busy=%b ffvec=%h cnt=%0d want 0 a5 1",
               busy_v[0], ffvec_v[0], cnt_v[0]);
    end

    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    found = 0;
    for (int c = 0; c < 300; c++) begin
      if (vec_v[0] === 8'h40) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (found !== 1) begin errors++; $display("FAIL abort_reach_40: got %0d want 1", found); end
    abort_v[0] = 1'b1;
    @(posedge clk); #1;
    abort_v[0] = 1'b0;
    checks++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0 || pass_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL abort_flags: busy=%b done=%b pass=%b want 0 0 0",
               busy_v[0], done_v[0], pass_v[0]);
    end
    checks++;
    if (vec_v[0] !== 8'h40) begin errors++; $display("FAIL abort_vec_hold: got %h want 40", vec_v[0]); end
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      if (done_v[0] || busy_v[0]) dones++;
      @(posedge clk); #1;
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL abort_no_done: got %0d active cycles want 0", dones); end

    sweep(0, 0, dc, bc, se);
    checks++;
    if (dc !== 257 || pass_v[0] !== 1'b1 || se !== 0) begin
      errors++;
      $display("FAIL restart: done_cycle=%0d pass=%b step_err=%0d want 257 1 0",
               dc, pass_v[0], se);
    end

    mode_v[0] = 1;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (30) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_v[0], done_v[0], pass_v[0], ffvalid_v[0]} !== 4'b0000 ||
        vec_v[0] !== 8'h00 || cnt_v[0] !== 9'h000 || ffvec_v[0] !== 8'h00) begin
      errors++;
      $display("FAIL midsweep_reset: flags=%b vec=%h cnt=%h ffvec=%h want 0000 00 000 00",
               {busy_v[0], done_v[0], pass_v[0], ffvalid_v[0]},
               vec_v[0], cnt_v[0], ffvec_v[0]);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_idle: busy=%b done=%b want 0 0", busy_v[0], done_v[0]);
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    start_v = 3'b000;
    abort_v = 3'b000;
    mode_v[0] = 0;
    mode_v[1] = 0;
    mode_v[2] = 0;
    rst_n = 1'b0;

    test_reset();
    test_match();
    test_inverted();
    test_single_fault();
    test_early_stop();
    test_settle();
    test_abort_restart_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
